// File: rtl/pe_gen2_pkg.sv
// Shared definitions for the gen2 processing element: state encoding,
// configuration word layout and default parameter values.
package pe_gen2_pkg;

    localparam int DEF_DATA_BITS = 32;
    localparam int DEF_LANE_BITS = 8;
    localparam int DEF_P_MAX     = 4;
    localparam int DEF_S_MAX     = 3;
    localparam int DEF_F_BITS    = 5;

    typedef enum logic [2:0] {
        IDLE,
        READ_FILTER,
        READ_IFMAP,
        CALC,
        READ_IPSUM,
        WRITE_OPSUM
    } state_t;

    // Config word, LSB-first: q | F | p | s | ipsum_en | ifmap_signed
    function automatic int cfg_f_lsb(int q_w, int f_w, int p_w, int s_w);
        return q_w + 0 * (f_w + p_w + s_w);
    endfunction

    function automatic int cfg_p_lsb(int q_w, int f_w, int p_w, int s_w);
        return q_w + f_w + 0 * (p_w + s_w);
    endfunction

    function automatic int cfg_s_lsb(int q_w, int f_w, int p_w, int s_w);
        return q_w + f_w + p_w + 0 * s_w;
    endfunction

    function automatic int cfg_en_bit(int q_w, int f_w, int p_w, int s_w);
        return q_w + f_w + p_w + s_w;
    endfunction

    function automatic int cfg_bits(int q_w, int f_w, int p_w, int s_w);
        return q_w + f_w + p_w + s_w + 2;
    endfunction

endpackage

// File: rtl/pe_gen2_mac.sv
// One packed-lane MAC step: pick a lane from each operand, signed multiply,
// sign-extend and add into the running channel sum.
module pe_gen2_mac
    import pe_gen2_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int LANE_BITS = DEF_LANE_BITS,
    parameter int Q_W       = 2
) (
    input  logic [DATA_BITS-1:0] filter_word,
    input  logic [DATA_BITS-1:0] ifmap_word,
    input  logic [Q_W-1:0]       lane,
    input  logic [DATA_BITS-1:0] acc_in,
    output logic [DATA_BITS-1:0] acc_out
);

    logic signed [LANE_BITS-1:0]   op_f;
    logic signed [LANE_BITS-1:0]   op_x;
    logic signed [2*LANE_BITS-1:0] prod;

    always_comb begin
        op_f    = filter_word[int'(lane)*LANE_BITS +: LANE_BITS];
        op_x    = ifmap_word[int'(lane)*LANE_BITS +: LANE_BITS];
        prod    = op_f * op_x;
        acc_out = acc_in + {{(DATA_BITS-2*LANE_BITS){prod[2*LANE_BITS-1]}}, prod};
    end

endmodule

// File: rtl/pe_gen2.sv
// Row-stationary processing element: loads filters, slides an ifmap window,
// accumulates packed-lane MACs per output channel and streams partial sums.
//
// state       | meaning
// IDLE        | waiting for PE_en; config latched on start
// READ_FILTER | loading (p+1)*(s+1) filter words, channel-major
// READ_IFMAP  | s+1 words for window 0, one word per later window
// CALC        | one lane MAC per cycle over lane, tap, channel
// READ_IPSUM  | adding one incoming partial sum per channel
// WRITE_OPSUM | emitting channels 0..p, then next window or IDLE
module pe_gen2
    import pe_gen2_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int LANE_BITS = DEF_LANE_BITS,
    parameter int P_MAX     = DEF_P_MAX,
    parameter int S_MAX     = DEF_S_MAX,
    parameter int F_BITS    = DEF_F_BITS,
    localparam int LANES    = DATA_BITS / LANE_BITS,
    localparam int Q_W      = $clog2(LANES),
    localparam int P_W      = $clog2(P_MAX),
    localparam int S_W      = $clog2(S_MAX),
    localparam int CFG_BITS = cfg_bits(Q_W, F_BITS, P_W, S_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PE_en,
    input  logic [CFG_BITS-1:0]  i_config,
    input  logic [DATA_BITS-1:0] filter,
    input  logic                 filter_valid,
    output logic                 filter_ready,
    input  logic [DATA_BITS-1:0] ifmap,
    input  logic                 ifmap_valid,
    output logic                 ifmap_ready,
    input  logic [DATA_BITS-1:0] ipsum,
    input  logic                 ipsum_valid,
    output logic                 ipsum_ready,
    output logic [DATA_BITS-1:0] opsum,
    output logic                 opsum_valid,
    input  logic                 opsum_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int F_LSB  = cfg_f_lsb(Q_W, F_BITS, P_W, S_W);
    localparam int P_LSB  = cfg_p_lsb(Q_W, F_BITS, P_W, S_W);
    localparam int S_LSB  = cfg_s_lsb(Q_W, F_BITS, P_W, S_W);
    localparam int EN_BIT = cfg_en_bit(Q_W, F_BITS, P_W, S_W);

    state_t state, state_nx;

    logic [CFG_BITS-1:0] cfg;
    logic [Q_W-1:0]      q_cfg;
    logic [F_BITS-1:0]   f_cfg;
    logic [P_W-1:0]      p_cfg;
    logic [S_W-1:0]      s_cfg;
    logic                ipsum_en;
    logic                ifmap_signed;

    logic [P_W-1:0]    p_cnt;
    logic [S_W-1:0]    t_cnt;
    logic [Q_W-1:0]    q_cnt;
    logic [F_BITS-1:0] win_cnt;

    logic [DATA_BITS-1:0] filt_spad [P_MAX][S_MAX];
    logic [DATA_BITS-1:0] tap       [S_MAX];
    logic [DATA_BITS-1:0] psum      [P_MAX];
    logic [DATA_BITS-1:0] ifmap_fix;
    logic [DATA_BITS-1:0] mac_acc;

    logic filter_xfer, ifmap_xfer, ipsum_xfer, opsum_xfer;
    logic p_last, t_last, q_last, win_last, ifmap_last;

    assign q_cfg        = cfg[0 +: Q_W];
    assign f_cfg        = cfg[F_LSB +: F_BITS];
    assign p_cfg        = cfg[P_LSB +: P_W];
    assign s_cfg        = cfg[S_LSB +: S_W];
    assign ipsum_en     = cfg[EN_BIT];
    assign ifmap_signed = cfg[EN_BIT+1];

    assign filter_xfer = filter_valid & filter_ready;
    assign ifmap_xfer  = ifmap_valid & ifmap_ready;
    assign ipsum_xfer  = ipsum_valid & ipsum_ready;
    assign opsum_xfer  = opsum_valid & opsum_ready;

    assign p_last     = (p_cnt == p_cfg);
    assign t_last     = (t_cnt == s_cfg);
    assign q_last     = (q_cnt == q_cfg);
    assign win_last   = (win_cnt == f_cfg);
    assign ifmap_last = (win_cnt == '0) ? t_last : 1'b1;

    assign opsum = (state == WRITE_OPSUM) ? psum[p_cnt] : '0;

    // Unsigned activations are re-biased into signed range lane by lane.
    always_comb begin
        ifmap_fix = ifmap;
        if (!ifmap_signed) begin
            for (int l = 0; l < LANES; l++) begin
                ifmap_fix[(l+1)*LANE_BITS-1] = ~ifmap[(l+1)*LANE_BITS-1];
            end
        end
    end

    pe_gen2_mac #(
        .DATA_BITS (DATA_BITS),
        .LANE_BITS (LANE_BITS),
        .Q_W       (Q_W)
    ) u_mac (
        .filter_word (filt_spad[p_cnt][t_cnt]),
        .ifmap_word  (tap[t_cnt]),
        .lane        (q_cnt),
        .acc_in      (psum[p_cnt]),
        .acc_out     (mac_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        filter_ready = 1'b0;
        ifmap_ready  = 1'b0;
        ipsum_ready  = 1'b0;
        opsum_valid  = 1'b0;
        busy         = (state != IDLE);
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (PE_en) state_nx = READ_FILTER;
            end
            READ_FILTER: begin
                filter_ready = 1'b1;
                if (filter_valid && p_last && t_last) state_nx = READ_IFMAP;
            end
            READ_IFMAP: begin
                ifmap_ready = 1'b1;
                if (ifmap_valid && ifmap_last) state_nx = CALC;
            end
            CALC: begin
                if (q_last && t_last && p_last) state_nx = ipsum_en ? READ_IPSUM : WRITE_OPSUM;
            end
            READ_IPSUM: begin
                ipsum_ready = 1'b1;
                if (ipsum_valid && p_last) state_nx = WRITE_OPSUM;
            end
            WRITE_OPSUM: begin
                opsum_valid = 1'b1;
                if (opsum_ready && p_last) begin
                    if (win_last) begin
                        state_nx = IDLE;
                        done     = 1'b1;
                    end else begin
                        state_nx = READ_IFMAP;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg     <= '0;
            p_cnt   <= '0;
            t_cnt   <= '0;
            q_cnt   <= '0;
            win_cnt <= '0;
            for (int i = 0; i < P_MAX; i++) psum[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    p_cnt   <= '0;
                    t_cnt   <= '0;
                    q_cnt   <= '0;
                    win_cnt <= '0;
                    for (int i = 0; i < P_MAX; i++) psum[i] <= '0;
                    if (PE_en) cfg <= i_config;
                end
                READ_FILTER: begin
                    if (filter_xfer) begin
                        t_cnt <= t_last ? '0 : t_cnt + 1'b1;
                        if (t_last) begin
                            p_cnt <= p_last ? '0 : p_cnt + 1'b1;
                            if (p_last) begin
                                for (int i = 0; i < P_MAX; i++)
                                    if (i <= int'(p_cfg)) psum[i] <= '0;
                            end
                        end
                    end
                end
                READ_IFMAP: begin
                    if (ifmap_xfer) t_cnt <= ifmap_last ? '0 : t_cnt + 1'b1;
                end
                CALC: begin
                    psum[p_cnt] <= mac_acc;
                    q_cnt       <= q_last ? '0 : q_cnt + 1'b1;
                    if (q_last) begin
                        t_cnt <= t_last ? '0 : t_cnt + 1'b1;
                        if (t_last) p_cnt <= p_last ? '0 : p_cnt + 1'b1;
                    end
                end
                READ_IPSUM: begin
                    if (ipsum_xfer) begin
                        psum[p_cnt] <= psum[p_cnt] + ipsum;
                        p_cnt       <= p_last ? '0 : p_cnt + 1'b1;
                    end
                end
                WRITE_OPSUM: begin
                    if (opsum_xfer) begin
                        p_cnt <= p_last ? '0 : p_cnt + 1'b1;
                        if (p_last) begin
                            win_cnt <= win_last ? '0 : win_cnt + 1'b1;
                            if (!win_last) begin
                                for (int i = 0; i < P_MAX; i++)
                                    if (i <= int'(p_cfg)) psum[i] <= '0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Filter and tap storage carry no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (filter_xfer) filt_spad[p_cnt][t_cnt] <= filter;
        if (ifmap_xfer) begin
            for (int i = 0; i < S_MAX; i++) begin
                if (i == int'(s_cfg)) tap[i] <= ifmap_fix;
                else if (i < int'(s_cfg)) tap[i] <= tap[(i+1) % S_MAX];
            end
        end
    end

endmodule

// File: tb/tb_pe_gen2.sv
// Self-checking bench for pe_gen2: directed scenarios plus randomized jobs
// compared against a sum-of-products reference model.
module tb_pe_gen2;

    logic        clk = 1'b0;
    logic        rst;
    logic        PE_en;
    logic [12:0] i_config;
    logic [31:0] filter, ifmap, ipsum, opsum;
    logic        filter_valid, filter_ready;
    logic        ifmap_valid, ifmap_ready;
    logic        ipsum_valid, ipsum_ready;
    logic        opsum_valid, opsum_ready;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    int cq, cs, cp, cF, cen, csg;
    int stall_w = -1, stall_c = 0, stall_len = 0;
    int done_cnt, ip_viol;
    logic mon_noip = 1'b0;

    logic [31:0] f_words  [16];
    logic [31:0] x_words  [40];
    logic [31:0] ip_words [32][4];
    logic [31:0] got      [32][4];

    pe_gen2 dut (
        .clk          (clk),
        .rst          (rst),
        .PE_en        (PE_en),
        .i_config     (i_config),
        .filter       (filter),
        .filter_valid (filter_valid),
        .filter_ready (filter_ready),
        .ifmap        (ifmap),
        .ifmap_valid  (ifmap_valid),
        .ifmap_ready  (ifmap_ready),
        .ipsum        (ipsum),
        .ipsum_valid  (ipsum_valid),
        .ipsum_ready  (ipsum_ready),
        .opsum        (opsum),
        .opsum_valid  (opsum_valid),
        .opsum_ready  (opsum_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_noip && ipsum_ready) ip_viol++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Channel ch of window w: dot product over taps and active lanes, plus ipsum.
    function automatic logic [31:0] model(input int w, input int ch);
        logic [31:0] acc;
        logic [31:0] fw, xw;
        logic [7:0]  fb, xb;
        acc = '0;
        for (int t = 0; t <= cs; t++) begin
            for (int l = 0; l <= cq; l++) begin
                fw  = f_words[ch*(cs+1)+t];
                xw  = x_words[w+t];
                fb  = fw[8*l +: 8];
                xb  = xw[8*l +: 8] ^ ((csg != 0) ? 8'h00 : 8'h80);
                acc = acc + 32'(int'($signed(fb)) * int'($signed(xb)));
            end
        end
        if (cen != 0) acc = acc + ip_words[w][ch];
        return acc;
    endfunction

    task automatic clear_data();
        for (int k = 0; k < 16; k++) f_words[k] = '0;
        for (int k = 0; k < 40; k++) x_words[k] = '0;
        for (int w = 0; w < 32; w++)
            for (int c = 0; c < 4; c++) ip_words[w][c] = '0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++) f_words[k] = $urandom;
        for (int k = 0; k < 40; k++) x_words[k] = $urandom;
        for (int w = 0; w < 32; w++)
            for (int c = 0; c < 4; c++) ip_words[w][c] = $urandom;
    endtask

    task automatic send(input int which, input logic [31:0] word);
        int n;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        case (which)
            0:       begin filter = word; filter_valid = 1'b1; end
            1:       begin ifmap  = word; ifmap_valid  = 1'b1; end
            default: begin ipsum  = word; ipsum_valid  = 1'b1; end
        endcase
        n = 0;
        while (n < 200 && !((which == 0 && filter_ready) || (which == 1 && ifmap_ready) ||
                            (which == 2 && ipsum_ready))) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_wait", n < 200, 1);
        @(negedge clk);
        filter_valid = 1'b0;
        ifmap_valid  = 1'b0;
        ipsum_valid  = 1'b0;
    endtask

    task automatic start_job();
        @(negedge clk);
        i_config = {1'(csg), 1'(cen), 2'(cs), 2'(cp), 5'(cF), 2'(cq)};
        PE_en    = 1'b1;
        @(negedge clk);
        PE_en    = 1'b0;
        i_config = 13'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic load_filters();
        for (int k = 0; k < (cp+1)*(cs+1); k++) send(0, f_words[k]);
    endtask

    task automatic run_window(input int w);
        int n;
        logic [31:0] hold;
        if (w == 0) begin
            for (int k = 0; k <= cs; k++) send(1, x_words[k]);
        end else begin
            send(1, x_words[w+cs]);
        end
        n = 0;
        while (busy && !filter_ready && !ifmap_ready && !ipsum_ready && !opsum_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("calc_cycles", n, (cp+1)*(cs+1)*(cq+1));
        if (cen != 0) begin
            for (int c = 0; c <= cp; c++) send(2, ip_words[w][c]);
        end
        for (int c = 0; c <= cp; c++) begin
            n = 0;
            while (!opsum_valid && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("opsum_wait", n < 500, 1);
            if (w == stall_w && c == stall_c) begin
                hold = opsum;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_opsum", opsum, hold);
                    chk("stall_valid", opsum_valid, 1);
                end
            end else if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
            end
            opsum_ready = 1'b1;
            #1;
            got[w][c] = opsum;
            chk("opsum", opsum, model(w, c));
            chk("done_flag", done, (w == cF && c == cp));
            if (done) done_cnt++;
            @(negedge clk);
            opsum_ready = 1'b0;
        end
    endtask

    task automatic run_job();
        done_cnt = 0;
        ip_viol  = 0;
        mon_noip = (cen == 0);
        start_job();
        load_filters();
        for (int w = 0; w <= cF; w++) run_window(w);
        chk("idle_after_job", busy, 0);
        chk("done_count", done_cnt, 1);
        if (cen == 0) chk("ipsum_ready_low", ip_viol, 0);
        mon_noip = 1'b0;
    endtask

    task automatic set_cfg(input int q, input int s, input int p, input int f,
                           input int en, input int sg);
        cq = q; cs = s; cp = p; cF = f; cen = en; csg = sg;
    endtask

    initial begin
        rst          = 1'b1;
        PE_en        = 1'b0;
        i_config     = '0;
        filter       = '0;
        ifmap        = '0;
        ipsum        = '0;
        filter_valid = 1'b0;
        ifmap_valid  = 1'b0;
        ipsum_valid  = 1'b0;
        opsum_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {filter_ready, ifmap_ready, ipsum_ready, opsum_valid, busy, done, opsum}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {filter_ready, ifmap_ready, ipsum_ready, opsum_valid, busy, done, opsum}, 0);

        // three-tap dot product plus ipsum
        clear_data();
        set_cfg(0, 2, 0, 0, 1, 1);
        f_words[0] = 1; f_words[1] = 2; f_words[2] = 3;
        x_words[0] = 4; x_words[1] = 5; x_words[2] = 6;
        ip_words[0][0] = 10;
        run_job();
        chk("three_tap_opsum", got[0][0], 42);

        // unsigned activations re-biased
        clear_data();
        set_cfg(0, 0, 0, 1, 0, 0);
        f_words[0] = 2;
        x_words[0] = 32'h0000_00FF;
        x_words[1] = 32'h0000_0080;
        run_job();
        chk("unsigned_ff", got[0][0], 254);
        chk("unsigned_80", got[1][0], 0);

        // four packed lanes
        clear_data();
        set_cfg(3, 0, 0, 0, 1, 1);
        f_words[0] = 32'h0101_0101;
        x_words[0] = 32'h0102_0304;
        run_job();
        chk("four_lane_opsum", got[0][0], 10);

        // sliding window reuse
        clear_data();
        set_cfg(0, 2, 0, 1, 0, 1);
        f_words[0] = 1; f_words[1] = 2; f_words[2] = 3;
        x_words[0] = 1; x_words[1] = 2; x_words[2] = 3; x_words[3] = 4;
        run_job();
        chk("slide_win0", got[0][0], 14);
        chk("slide_win1", got[1][0], 20);

        // four channels with backpressure mid-stream
        fill_random();
        set_cfg(1, 1, 3, 0, 1, 1);
        stall_w = 0; stall_c = 1; stall_len = 5;
        run_job();
        stall_w = -1;

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            fill_random();
            set_cfg($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1));
            if (j == 3) begin
                stall_w = 0; stall_c = cp; stall_len = $urandom_range(1, 4);
            end
            run_job();
            stall_w = -1;
        end

        // reset landing in CALC, then a clean restart
        fill_random();
        set_cfg(3, 2, 3, 1, 1, 1);
        done_cnt = 0;
        start_job();
        load_filters();
        for (int k = 0; k <= cs; k++) send(1, x_words[k]);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_async", {filter_ready, ifmap_ready, ipsum_ready, opsum_valid, busy, done, opsum}, 0);
        @(posedge clk);
        #1;
        chk("rst_mid_edge", {filter_ready, ifmap_ready, ipsum_ready, opsum_valid, busy, done, opsum}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", {busy, done}, 0);
        fill_random();
        set_cfg(2, 1, 2, 1, 0, 0);
        run_job();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
